fft_ram_wr_ctrl: RTL and testbench

- Parametrised write-side controller for the burst FFT/IFFT two-bank (A/B) working memory.
- Loads one input frame from a valid/ready stream into banks A/B, with optional bit-reversed addressing.
- Then steers per-level butterfly write-backs to both banks, tracks level and frame completion, and flags protocol errors.
- Successor to the fixed-case write block: generic length up to 2^MAX_LOG2, selectable input ordering, explicit FSM, backpressure, abort and error reporting.

---
 rtl/fft_pkg.sv | 9 +
 rtl/fft_ram_wr_ctrl_if.sv | 40 ++++
 rtl/fft_bitrev_addr.sv | 17 +
 rtl/fft_ram_wr_ctrl.sv | 113 +++++++++++
 tb/tb_fft_ram_wr_ctrl.sv | 125 ++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, minimum length and length clamp for the FFT RAM write side
// No ports; imported by fft_ram_wr_ctrl and its sub-module.
package fft_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;
  localparam logic [3:0] LOG2_MIN = 4'd3;
  function automatic logic [3:0] clamp_log2(input logic [3:0] l, input logic [3:0] max_l);
    return l < LOG2_MIN ? LOG2_MIN : l > max_l ? max_l : l;
  endfunction
endpackage

// File: rtl/fft_ram_wr_ctrl_if.sv
// fft_ram_wr_ctrl_if: config, input stream, butterfly results, bank writes and status of the write controller
// Ports: slave = controller side, master = source/sink side.
interface fft_ram_wr_ctrl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 14
);
  logic [3:0] cfg_log2_len;
  logic cfg_bitrev;
  logic abort;
  logic s_axi_valid;
  logic s_axi_ready;
  logic s_axi_last;
  logic [DATA_WIDTH-1:0] s_axi_data;
  logic o_wr_valid;
  logic [ADDR_WIDTH-1:0] o_wr_index;
  logic [DATA_WIDTH-1:0] ao_wr_data;
  logic [DATA_WIDTH-1:0] bo_wr_data;
  logic a_wr_en;
  logic [DATA_WIDTH-1:0] a_wr_data;
  logic b_wr_en;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0] lev_cnt;
  logic lev_done;
  logic frame_done;
  logic err_len;
  logic err_unexp;
  modport slave (
    input cfg_log2_len, cfg_bitrev, abort, s_axi_valid, s_axi_last, s_axi_data,
          o_wr_valid, o_wr_index, ao_wr_data, bo_wr_data,
    output s_axi_ready, a_wr_en, a_wr_data, b_wr_en, b_wr_data, wr_addr,
           lev_cnt, lev_done, frame_done, err_len, err_unexp
  );
  modport master (
    output cfg_log2_len, cfg_bitrev, abort, s_axi_valid, s_axi_last, s_axi_data,
           o_wr_valid, o_wr_index, ao_wr_data, bo_wr_data,
    input s_axi_ready, a_wr_en, a_wr_data, b_wr_en, b_wr_data, wr_addr,
          lev_cnt, lev_done, frame_done, err_len, err_unexp
  );
endinterface

// File: rtl/fft_bitrev_addr.sv
// fft_bitrev_addr: reverses address j over l-1 bits, upper bits zero
// Ports: j (in-bank index, bits above l-2 zero), l (log2 length), rev (reversed address).
module fft_bitrev_addr #(
  parameter int MAX_LOG2 = 15
) (
  input  logic [MAX_LOG2-2:0] j,
  input  logic [3:0]          l,
  output logic [MAX_LOG2-2:0] rev
);
  localparam int AW = MAX_LOG2 - 1;
  logic [AW-1:0] full;
  // reverse over the full width, then shift down so the reversal spans only l-1 bits
  for (genvar i = 0; i < AW; i++) begin : g_rev
    assign full[i] = j[AW-1-i];
  end
  assign rev = full >> (4'(MAX_LOG2) - l);
endmodule

// File: rtl/fft_ram_wr_ctrl.sv
// fft_ram_wr_ctrl: loads a frame into banks A/B then steers butterfly write-backs per level
// Ports: clk, rst (async, active-high), bus (fft_ram_wr_ctrl_if.slave: cfg, stream in, results in, bank writes and status out).
module fft_ram_wr_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int MAX_LOG2   = 15,
  parameter int ADDR_WIDTH = MAX_LOG2 - 1
) (
  input logic clk,
  input logic rst,
  fft_ram_wr_ctrl_if.slave bus
);
  state_t state;
  logic [3:0] l_reg, l_eff;
  logic bitrev_reg, bitrev_eff, accept, bank;
  logic [MAX_LOG2-1:0] k, k_eff, k_max;
  logic [ADDR_WIDTH-1:0] j, rev_j, ld_addr, wcnt, wcnt_max;
  // in IDLE the accepting beat uses the live config, afterwards the latched copy
  assign l_eff      = state == IDLE ? clamp_log2(bus.cfg_log2_len, 4'(MAX_LOG2)) : l_reg;
  assign bitrev_eff = state == IDLE ? bus.cfg_bitrev : bitrev_reg;
  assign k_eff      = state == IDLE ? '0 : k;
  assign k_max      = MAX_LOG2'((32'd1 << l_eff) - 32'd1);
  assign bank       = |(k_eff & MAX_LOG2'(32'd1 << (l_eff - 4'd1)));
  assign j          = ADDR_WIDTH'(k_eff) & ADDR_WIDTH'((32'd1 << (l_eff - 4'd1)) - 32'd1);
  assign ld_addr    = bitrev_eff ? rev_j : j;
  assign wcnt_max   = ADDR_WIDTH'((32'd1 << (l_reg - 4'd1)) - 32'd1);
  assign accept     = bus.s_axi_valid & bus.s_axi_ready;
  fft_bitrev_addr #(.MAX_LOG2(MAX_LOG2)) u_rev (.j(j), .l(l_eff), .rev(rev_j));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      l_reg           <= LOG2_MIN;
      bitrev_reg      <= 1'b0;
      k               <= '0;
      wcnt            <= '0;
      bus.s_axi_ready <= 1'b0;
      bus.a_wr_en     <= 1'b0;
      bus.b_wr_en     <= 1'b0;
      bus.a_wr_data   <= '0;
      bus.b_wr_data   <= '0;
      bus.wr_addr     <= '0;
      bus.lev_cnt     <= '0;
      bus.lev_done    <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err_len     <= 1'b0;
      bus.err_unexp   <= 1'b0;
    end else if (bus.abort) begin
      state           <= IDLE;
      k               <= '0;
      wcnt            <= '0;
      bus.s_axi_ready <= 1'b1;
      bus.a_wr_en     <= 1'b0;
      bus.b_wr_en     <= 1'b0;
      bus.lev_cnt     <= '0;
      bus.lev_done    <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err_len     <= 1'b0;
      bus.err_unexp   <= 1'b0;
    end else begin
      bus.a_wr_en    <= 1'b0;
      bus.b_wr_en    <= 1'b0;
      bus.lev_done   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_len    <= 1'b0;
      bus.err_unexp  <= bus.o_wr_valid & (state != COMPUTE);
      if (state == COMPUTE) begin
        if (bus.o_wr_valid) begin
          bus.a_wr_en   <= 1'b1;
          bus.b_wr_en   <= 1'b1;
          bus.wr_addr   <= bus.o_wr_index;
          bus.a_wr_data <= bus.ao_wr_data;
          bus.b_wr_data <= bus.bo_wr_data;
          wcnt          <= wcnt == wcnt_max ? '0 : wcnt + ADDR_WIDTH'(1);
          if (wcnt == wcnt_max) begin
            bus.lev_done <= 1'b1;
            if (bus.lev_cnt == l_reg - 4'd1) begin
              bus.frame_done  <= 1'b1;
              bus.lev_cnt     <= '0;
              bus.s_axi_ready <= 1'b1;
              state           <= IDLE;
            end else
              bus.lev_cnt <= bus.lev_cnt + 4'd1;
          end
        end
      end else begin
        bus.s_axi_ready <= 1'b1;
        if (accept) begin
          bus.a_wr_en   <= ~bank;
          bus.b_wr_en   <= bank;
          bus.a_wr_data <= bus.s_axi_data;
          bus.b_wr_data <= bus.s_axi_data;
          bus.wr_addr   <= ld_addr;
          l_reg         <= l_eff;
          bitrev_reg    <= bitrev_eff;
          if (k_eff == k_max) begin
            state           <= COMPUTE;
            bus.s_axi_ready <= 1'b0;
            bus.err_len     <= ~bus.s_axi_last;
            k               <= '0;
            wcnt            <= '0;
          end else if (bus.s_axi_last) begin
            state       <= IDLE;
            bus.err_len <= 1'b1;
            k           <= '0;
          end else begin
            state <= LOAD;
            k     <= k_eff + MAX_LOG2'(1);
          end
        end
      end
    end
endmodule

// File: tb/tb_fft_ram_wr_ctrl.sv
// tb_fft_ram_wr_ctrl: directed self-checking bench for fft_ram_wr_ctrl
module tb_fft_ram_wr_ctrl;
  localparam int DW = 18;
  localparam int ML = 15;
  localparam int AW = ML - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fft_ram_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  fft_ram_wr_ctrl #(.DATA_WIDTH(DW), .MAX_LOG2(ML)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int rev(input int j, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) if (j[b]) r |= 1 << (bits - 1 - b);
    return r;
  endfunction
  task automatic send(input int d, input bit last, input bit ov, input bit eb, input int ea, input bit elen);
    bus.s_axi_valid = 1'b1;
    bus.s_axi_data  = DW'(d);
    bus.s_axi_last  = last;
    bus.o_wr_valid  = ov;
    @(posedge clk); #1;
    bus.s_axi_valid = 1'b0;
    bus.s_axi_last  = 1'b0;
    bus.o_wr_valid  = 1'b0;
    check("ld_en", {bus.a_wr_en, bus.b_wr_en}, eb ? 2'b01 : 2'b10);
    check("ld_addr", bus.wr_addr, ea);
    check("ld_data", eb ? bus.b_wr_data : bus.a_wr_data, d);
    check("err_len", bus.err_len, elen);
    check("err_unexp", bus.err_unexp, ov);
  endtask
  task automatic load(input int cfg, input int l, input bit br, input int nb, input int last_at, input int ov_at);
    int n = 1 << l;
    bus.cfg_log2_len = 4'(cfg);
    bus.cfg_bitrev   = br;
    for (int k = 0; k < nb; k++) begin
      send(k + 16, k == last_at, k == ov_at, k >= n / 2, br ? rev(k % (n / 2), l - 1) : k % (n / 2), (k == n - 1) ^ (k == last_at));
      bus.cfg_log2_len = 4'd9;
      bus.cfg_bitrev   = ~br;
    end
  endtask
  task automatic result(input int idx, input int w, input int lev, input bit ld, input bit fd);
    bus.o_wr_valid = 1'b1;
    bus.o_wr_index = AW'(idx);
    bus.ao_wr_data = DW'(100 + w);
    bus.bo_wr_data = DW'(200 + w);
    @(posedge clk); #1;
    bus.o_wr_valid = 1'b0;
    check("res_en", {bus.a_wr_en, bus.b_wr_en}, 2'b11);
    check("res_addr", bus.wr_addr, idx);
    check("res_a", bus.a_wr_data, 100 + w);
    check("res_b", bus.b_wr_data, 200 + w);
    check("lev_done", bus.lev_done, ld);
    check("frame_done", bus.frame_done, fd);
    check("lev_cnt", bus.lev_cnt, lev);
  endtask
  task automatic do_abort();
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("ab_en", {bus.a_wr_en, bus.b_wr_en}, 2'b00);
    check("ab_lev", bus.lev_cnt, 0);
    check("ab_fd", bus.frame_done, 0);
    check("ab_ready", bus.s_axi_ready, 1);
  endtask
  initial begin
    bus.cfg_log2_len = 4'd3;
    bus.cfg_bitrev   = 1'b0;
    bus.abort        = 1'b0;
    bus.s_axi_valid  = 1'b0;
    bus.s_axi_last   = 1'b0;
    bus.s_axi_data   = '0;
    bus.o_wr_valid   = 1'b0;
    bus.o_wr_index   = '0;
    bus.ao_wr_data   = '0;
    bus.bo_wr_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.s_axi_ready, 0);
    check("rst_en", {bus.a_wr_en, bus.b_wr_en}, 2'b00);
    check("rst_lev", bus.lev_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", bus.s_axi_ready, 1);
    load(3, 3, 1, 8, 7, -1);
    check("t1_ready", bus.s_axi_ready, 0);
    for (int w = 1; w <= 12; w++) result((w - 1) % 4, w, (w / 4) % 3, w % 4 == 0, w == 12);
    check("t1_idle_ready", bus.s_axi_ready, 1);
    load(4, 4, 0, 16, 15, -1);
    check("t2_ready", bus.s_axi_ready, 0);
    do_abort();
    load(3, 3, 1, 5, 4, -1);
    check("short_ready", bus.s_axi_ready, 1);
    load(3, 3, 1, 8, -1, -1);
    check("nolast_ready", bus.s_axi_ready, 0);
    do_abort();
    load(3, 3, 1, 8, 7, -1);
    for (int w = 1; w <= 5; w++) result((w - 1) % 4, w, w / 4, w == 4, 1'b0);
    do_abort();
    load(3, 3, 1, 8, 7, -1);
    check("reload_ready", bus.s_axi_ready, 0);
    do_abort();
    load(1, 3, 0, 8, 7, -1);
    check("clamp_ready", bus.s_axi_ready, 0);
    do_abort();
    load(3, 3, 1, 8, 7, 2);
    check("unexp_ready", bus.s_axi_ready, 0);
    do_abort();
    bus.o_wr_valid = 1'b1;
    @(posedge clk); #1;
    bus.o_wr_valid = 1'b0;
    check("idle_unexp", bus.err_unexp, 1);
    check("idle_unexp_en", {bus.a_wr_en, bus.b_wr_en}, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
